// File: rtl/korev_mem_pkg.sv
// Shared types and default widths for the memory port arbiter.
package korev_mem_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; otherwise D wins.
module mem_arb_pick
    import korev_mem_pkg::*;
(
    input  logic       ireq,
    input  logic       dreq,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  arb_grant_t last_grant,
`endif
    output logic       grant_valid,
    output arb_grant_t grant
);

    always_comb begin
        grant_valid = ireq | dreq;
        grant       = GRANT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (ireq && dreq)
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        else if (dreq)
            grant = GRANT_D;
`else
        if (dreq)
            grant = GRANT_D;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requests onto one req/ack memory port.
// Contention policy set by MEM_ARB_ROUND_ROBIN_EN (round-robin) or fixed D-first.
module mem_port_arbiter
    import korev_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ireq,
    input  logic [ADDR_W-1:0]   iaddr,
    output logic                idrdy,
    output logic [DATA_W-1:0]   irdata,
    input  logic                dreq,
    input  logic                dwe,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W-1:0]   dwdata,
    input  logic [DATA_W/8-1:0] dwstrb,
    output logic                ddrdy,
    output logic [DATA_W-1:0]   drdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state;
    logic       grant_valid;
    arb_grant_t grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant;
`endif

    mem_arb_pick u_pick (
        .ireq        (ireq),
        .dreq        (dreq),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_grant  (last_grant),
`endif
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idrdy     <= 1'b0;
            irdata    <= '0;
            ddrdy     <= 1'b0;
            drdata    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant <= GRANT_I;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        mem_req <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                        if (grant == GRANT_D) begin
                            state     <= BUSY_D;
                            mem_we    <= dwe;
                            mem_addr  <= daddr;
                            mem_wdata <= dwdata;
                            mem_wstrb <= dwstrb;
                        end else begin
                            // Fetch is always a full-word read with no byte enables
                            state     <= BUSY_I;
                            mem_we    <= 1'b0;
                            mem_addr  <= iaddr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state   <= RESP_I;
                        mem_req <= 1'b0;
                        idrdy   <= 1'b1;
                        irdata  <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state   <= RESP_D;
                        mem_req <= 1'b0;
                        ddrdy   <= 1'b1;
                        if (!mem_we)
                            drdata <= mem_rdata;
                    end
                end
                RESP_I: begin
                    state <= IDLE;
                    idrdy <= 1'b0;
                end
                RESP_D: begin
                    state <= IDLE;
                    ddrdy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    idrdy   <= 1'b0;
                    ddrdy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (both MEM_ARB_ROUND_ROBIN_EN builds).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        idrdy;
    logic [31:0] irdata;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwstrb;
    logic        ddrdy;
    logic [31:0] drdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ireq      (ireq),
        .iaddr     (iaddr),
        .idrdy     (idrdy),
        .irdata    (irdata),
        .dreq      (dreq),
        .dwe       (dwe),
        .daddr     (daddr),
        .dwdata    (dwdata),
        .dwstrb    (dwstrb),
        .ddrdy     (ddrdy),
        .drdata    (drdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Contended round: expects grant to the given address, acks at once.
    task automatic contended_round(input string tag, input logic [31:0] exp_addr,
                                   input logic exp_d);
        tick();
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, exp_addr);
        mem_ack   = 1'b1;
        mem_rdata = exp_addr + 32'h100;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_ddrdy"}, {31'd0, ddrdy}, {31'd0, exp_d});
        chk({tag, "_idrdy"}, {31'd0, idrdy}, {31'd0, ~exp_d});
        if (exp_d) dreq = 1'b0;
        else       ireq = 1'b0;
        tick();
        if (exp_d) dreq = 1'b1;
        else       ireq = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ireq = 1'b0; iaddr = '0; dreq = 1'b0; dwe = 1'b0;
        daddr = '0; dwdata = '0; dwstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_idrdy",   {31'd0, idrdy},   32'd0);
        chk("rst_ddrdy",   {31'd0, ddrdy},   32'd0);
        chk("rst_irdata",  irdata,           32'd0);
        chk("rst_drdata",  drdata,           32'd0);
        chk("rst_mem_addr", mem_addr,        32'd0);

        // Lone fetch, ack in first mem_req cycle
        ireq = 1'b1; iaddr = 32'h10;
        tick();
        chk("if_mem_req",   {31'd0, mem_req}, 32'd1);
        chk("if_mem_addr",  mem_addr, 32'h10);
        chk("if_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("if_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("if_idrdy_n1",  {31'd0, idrdy}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0; ireq = 1'b0;
        chk("if_idrdy",   {31'd0, idrdy}, 32'd1);
        chk("if_irdata",  irdata, 32'hDEADBEEF);
        chk("if_req_low", {31'd0, mem_req}, 32'd0);
        tick();
        chk("if_idrdy_off", {31'd0, idrdy}, 32'd0);
        chk("if_no_regrant", {31'd0, mem_req}, 32'd0);
        tick();
        chk("if_still_idle", {31'd0, mem_req}, 32'd0);

        // Data read
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h30; dwdata = 32'h0; dwstrb = 4'hF;
        tick();
        chk("dr_mem_addr", mem_addr, 32'h30);
        chk("dr_mem_we",   {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0; dreq = 1'b0;
        chk("dr_ddrdy",  {31'd0, ddrdy}, 32'd1);
        chk("dr_drdata", drdata, 32'hCAFEF00D);
        chk("dr_irdata_kept", irdata, 32'hDEADBEEF);
        tick();

        // Data write, ack after 3 wait cycles
        dreq = 1'b1; dwe = 1'b1; daddr = 32'h20; dwdata = 32'h12345678; dwstrb = 4'b0011;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("dw_mem_req",   {31'd0, mem_req}, 32'd1);
            chk("dw_mem_addr",  mem_addr, 32'h20);
            chk("dw_mem_we",    {31'd0, mem_we}, 32'd1);
            chk("dw_mem_wdata", mem_wdata, 32'h12345678);
            chk("dw_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
            chk("dw_ddrdy_wait", {31'd0, ddrdy}, 32'd0);
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
            end
            tick();
        end
        mem_ack = 1'b0; dreq = 1'b0; dwe = 1'b0;
        chk("dw_ddrdy",       {31'd0, ddrdy}, 32'd1);
        chk("dw_drdata_kept", drdata, 32'hCAFEF00D);
        chk("dw_req_low",     {31'd0, mem_req}, 32'd0);
        tick();
        chk("dw_ddrdy_once",  {31'd0, ddrdy}, 32'd0);
        tick();

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // Round-robin from a fresh reset: D, I, D
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ireq = 1'b1; iaddr = 32'h40; dreq = 1'b1; dwe = 1'b0; daddr = 32'h50;
        contended_round("rr1", 32'h50, 1'b1);
        contended_round("rr2", 32'h40, 1'b0);
        contended_round("rr3", 32'h50, 1'b1);
        ireq = 1'b0; dreq = 1'b0;
        tick(); tick(); tick();
`else
        // Fixed priority: D first, then I from the following IDLE cycle
        ireq = 1'b1; iaddr = 32'h40; dreq = 1'b1; dwe = 1'b0; daddr = 32'h50;
        tick();
        chk("fp_first_addr", mem_addr, 32'h50);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0; dreq = 1'b0;
        chk("fp_ddrdy",  {31'd0, ddrdy}, 32'd1);
        chk("fp_idrdy0", {31'd0, idrdy}, 32'd0);
        chk("fp_drdata", drdata, 32'h11111111);
        tick();
        chk("fp_idle_gap", {31'd0, mem_req}, 32'd0);
        tick();
        chk("fp_i_req",  {31'd0, mem_req}, 32'd1);
        chk("fp_i_addr", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        tick();
        mem_ack = 1'b0; ireq = 1'b0;
        chk("fp_idrdy",  {31'd0, idrdy}, 32'd1);
        chk("fp_irdata", irdata, 32'h22222222);
        tick();
`endif

        // Reset during BUSY_D
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h60;
        tick();
        chk("rb_busy", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rb_mem_req",  {31'd0, mem_req}, 32'd0);
        chk("rb_mem_addr", mem_addr, 32'd0);
        chk("rb_ddrdy",    {31'd0, ddrdy}, 32'd0);
        chk("rb_drdata",   drdata, 32'd0);
        chk("rb_irdata",   irdata, 32'd0);
        dreq = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        tick();
        mem_ack = 1'b0;
        rst = 1'b0;
        tick();
        chk("rb_no_ddrdy", {31'd0, ddrdy}, 32'd0);
        ireq = 1'b1; iaddr = 32'h70;
        tick();
        chk("rb_fresh_addr", mem_addr, 32'h70);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_ack = 1'b0; ireq = 1'b0;
        chk("rb_fresh_idrdy",  {31'd0, idrdy}, 32'd1);
        chk("rb_fresh_irdata", irdata, 32'hA5A5A5A5);
        tick();

        // Load one D value, then spurious ack in IDLE
        dreq = 1'b1; dwe = 1'b0; daddr = 32'h80;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h5A5A0000;
        tick();
        mem_ack = 1'b0; dreq = 1'b0;
        chk("sp_pre_drdata", drdata, 32'h5A5A0000);
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0;
        chk("sp_idrdy",   {31'd0, idrdy}, 32'd0);
        chk("sp_ddrdy",   {31'd0, ddrdy}, 32'd0);
        chk("sp_mem_req", {31'd0, mem_req}, 32'd0);
        chk("sp_irdata",  irdata, 32'hA5A5A5A5);
        chk("sp_drdata",  drdata, 32'h5A5A0000);
        tick();
        chk("sp_idrdy_late", {31'd0, idrdy}, 32'd0);
        chk("sp_ddrdy_late", {31'd0, ddrdy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
